// File: rtl/sha256_gpio_host.sv
// Host-side driver for the byte-wide GPIO SHA-256 core: streams message bytes in, collects the 32-byte digest.
// Optional feature macro SHA_HOST_TIMEOUT_EN: abort digest collection after TIMEOUT_CYCLES idle cycles.
module sha256_gpio_host #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       gpio_din,
  output logic             gpio_valid,
  output logic             gpio_last,
  input  logic             gpio_ready,
  input  logic             gpio_busy,
  input  logic [7:0]       gpio_dout,
  input  logic             gpio_dvalid,
  output logic [255:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ack,
  output logic [LEN_W-1:0] msg_len,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] byte_cnt;
  logic       send_start, byte_xfer, last_xfer, digest_byte, timeout_hit;

  assign send_start  = (state == IDLE) && s_valid && !gpio_busy;
  // A byte is only offered when the core is ready, so its skid buffer is never exercised.
  assign byte_xfer   = (state == SEND) && s_valid && gpio_ready;
  assign last_xfer   = byte_xfer && s_last;
  assign digest_byte = (state == COLLECT) && gpio_dvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: non-blocking so every register in the design samples pre-edge values.
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt  = state;
    s_ready    = 1'b0;
    gpio_valid = 1'b0;
    gpio_din   = '0;
    gpio_last  = 1'b0;
    unique case (state)
      IDLE: if (send_start) state_nxt = SEND;
      SEND: begin
        gpio_valid = byte_xfer;
        s_ready    = byte_xfer;
        gpio_din   = s_data;
        gpio_last  = s_last;
        if (last_xfer) state_nxt = COLLECT;
      end
      COLLECT: if ((digest_byte && byte_cnt == 5'd31) || timeout_hit) state_nxt = DONE;
      DONE:    if (digest_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest       <= '0;
      digest_valid <= 1'b0;
      msg_len      <= '0;
      byte_cnt     <= '0;
    end else begin
      if (send_start) msg_len <= '0;
      if (byte_xfer && msg_len != '1) msg_len <= msg_len + 1'b1;
      if (last_xfer) begin
        byte_cnt     <= '0;
        digest_valid <= 1'b0;
      end
      // First byte received ends up in the top byte once all 32 have shifted in.
      if (digest_byte) begin
        digest   <= {digest[247:0], gpio_dout};
        byte_cnt <= byte_cnt + 5'd1;
        if (byte_cnt == 5'd31) digest_valid <= 1'b1;
      end
      if (timeout_hit) digest_valid <= 1'b1;
      if (state == DONE && digest_ack) digest_valid <= 1'b0;
    end
  end

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive collect cycle without a digest byte.
  assign timeout_hit = (state == COLLECT) && !gpio_dvalid &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != COLLECT || gpio_dvalid) idle_cnt <= '0;
      else if (!timeout_hit)               idle_cnt <= idle_cnt + 1'b1;
      if (send_start)       err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_gpio_host.sv
// Scoreboard bench for sha256_gpio_host: the bench plays upstream source, GPIO core and digest consumer.
// Expected digests come from a model of "the last 32 digest bytes received since reset".
module tb_sha256_gpio_host;

  localparam int LEN_W = 4;   // small so a 64-byte message exercises msg_len saturation
  localparam int TMO   = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [255:0]     digest;
    logic [LEN_W-1:0] len;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       s_data;
  logic             s_valid, s_last, s_ready;
  logic [7:0]       gpio_din;
  logic             gpio_valid, gpio_last, gpio_ready, gpio_busy;
  logic [7:0]       gpio_dout;
  logic             gpio_dvalid;
  logic [255:0]     digest;
  logic             digest_valid, digest_ack;
  logic [LEN_W-1:0] msg_len;
  logic             err_timeout;

  always #5 clk = ~clk;

  sha256_gpio_host #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .gpio_din(gpio_din), .gpio_valid(gpio_valid), .gpio_last(gpio_last),
    .gpio_ready(gpio_ready), .gpio_busy(gpio_busy),
    .gpio_dout(gpio_dout), .gpio_dvalid(gpio_dvalid),
    .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack),
    .msg_len(msg_len), .err_timeout(err_timeout)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   proto_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bq_t  window;   // last 32 digest bytes accepted in COLLECT since reset
  bq_t  rx_q;     // bytes the core saw on gpio_din
  logic dv_q = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [255:0] pack(input bq_t w);
    logic [255:0] v = '0;
    foreach (w[i]) v = {v[247:0], w[i]};
    return v;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Core-side monitor and digest scoreboard.
  always @(negedge clk) begin
    if (gpio_valid) rx_q.push_back(gpio_din);
    if (gpio_valid && !gpio_ready) proto_err++;
    if (s_ready !== gpio_valid) proto_err++;
    if (s_ready && digest_valid) proto_err++;
    if (digest_valid && !dv_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_digest: got %h, expected none", digest);
      end else begin
        mon_e = exp_q.pop_front();
        check("digest", digest, mon_e.digest);
        check("msg_len", 256'(msg_len), 256'(mon_e.len));
        check("err_timeout", 256'(err_timeout), 256'(mon_e.err));
      end
    end
    dv_q = digest_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_window();
    window.delete();
    for (int i = 0; i < 32; i++) window.push_back(8'h00);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_strobes"}, 256'({s_ready, gpio_valid, gpio_last, gpio_din}), 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
    check({tag, "_regs"}, 256'({digest_valid, msg_len, err_timeout}), 256'(0));
  endtask

  // mode: 0 ready always high, 1 ready toggling, 2 random ready and random upstream gaps
  task automatic send_msg(input bq_t msg, input int mode);
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    bit tg  = 1'b1;
    rx_q.delete();
    while (idx < msg.size() && cyc < 2000) begin
      s_valid = (mode == 2) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = msg[idx];
      s_last  = (idx == msg.size() - 1);
      case (mode)
        0:       gpio_ready = 1'b1;
        1:       begin gpio_ready = tg; tg = !tg; end
        default: gpio_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (gpio_valid) idx++;
      tick();
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; gpio_ready = 1'b0;
    if (idx < msg.size()) begin
      n_checks++;
      $display("FAIL send_bound: sent %0d of %0d bytes", idx, msg.size());
    end
    if (rx_q.size() != msg.size()) bad++;
    else foreach (msg[i]) if (rx_q[i] !== msg[i]) bad++;
    check("tx_bytes", 256'(bad), 256'(0));
  endtask

  task automatic deliver(input bq_t dig, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        gpio_dvalid = 1'b0;
        tick();
      end
      gpio_dvalid = 1'b1;
      gpio_dout   = dig[i];
      tick();
      window.push_back(dig[i]);
      void'(window.pop_front());
    end
    gpio_dvalid = 1'b0;
  endtask

  // Queue the expected result, then run the message and return n digest bytes.
  task automatic run_msg(input bq_t msg, input int mode, input bq_t dig, input int n, input bit err);
    exp_t e;
    bq_t  w = window;
    int   mx = (1 << LEN_W) - 1;
    for (int i = 0; i < n; i++) begin
      w.push_back(dig[i]);
      void'(w.pop_front());
    end
    e.digest = pack(w);
    e.len    = LEN_W'((msg.size() > mx) ? mx : msg.size());
    e.err    = err;
    exp_q.push_back(e);
    send_msg(msg, mode);
    deliver(dig, n);
  endtask

  task automatic ack_digest();
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    @(negedge clk);
    check("ack_clears_valid", 256'(digest_valid), 256'(0));
    tick();
  endtask

  task automatic full_msg(input bq_t msg, input int mode, input bq_t dig);
    run_msg(msg, mode, dig, 32, 1'b0);
    @(negedge clk);
    check("valid_on_32nd", 256'(digest_valid), 256'(1));
    tick();
    ack_digest();
  endtask

  initial begin
    bq_t          m, d, abc, abc_d;
    logic [255:0] abc_v, hold_v;
    int           bad, cnt;

    abc_v = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    for (int i = 0; i < 32; i++) abc_d.push_back(abc_v[255 - 8*i -: 8]);
    abc = '{8'h61, 8'h62, 8'h63};
    reset_window();

    // Reset with upstream actively pushing: nothing may leak out.
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
    gpio_ready = 1'b1; gpio_busy = 1'b0; gpio_dout = 8'h00; gpio_dvalid = 1'b0;
    digest_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    s_valid = 1'b0; s_last = 1'b0; gpio_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // "abc" with the core always ready.
    full_msg(abc, 0, abc_d);

    // Stray digest byte and ack while idle are ignored.
    gpio_dvalid = 1'b1; gpio_dout = 8'hAA; digest_ack = 1'b1;
    tick();
    gpio_dvalid = 1'b0; digest_ack = 1'b0;
    @(negedge clk);
    check("stray_dvalid_digest", digest, pack(window));
    check("stray_dvalid_valid", 256'(digest_valid), 256'(0));
    tick();

    // "abc" with gpio_ready toggling every cycle.
    full_msg(abc, 1, abc_d);

    // 64 zero bytes; consumer delays its ack 20 cycles while upstream keeps pushing.
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'h00);
    d = rand_bytes(32);
    run_msg(m, 0, d, 32, 1'b0);
    hold_v = pack(window);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom); gpio_ready = 1'b1;
      @(negedge clk);
      if (digest_valid !== 1'b1 || digest !== hold_v) bad++;
      tick();
    end
    s_valid = 1'b0; gpio_ready = 1'b0;
    check("hold_stable", 256'(bad), 256'(0));
    ack_digest();

    // Core busy blocks the start of a message.
    gpio_busy = 1'b1; s_valid = 1'b1; s_data = 8'h5A; gpio_ready = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (gpio_valid || s_ready) bad++;
      tick();
    end
    check("busy_blocks_start", 256'(bad), 256'(0));
    gpio_busy = 1'b0; s_valid = 1'b0; gpio_ready = 1'b0;
    tick();

    // Randomised messages with random back-pressure.
    for (int k = 0; k < 6; k++) full_msg(rand_bytes($urandom_range(1, 20)), 2, rand_bytes(32));

    // Reset after 10 digest bytes discards the partial digest.
    run_msg(abc, 0, abc_d, 10, 1'b0);
    void'(exp_q.pop_back());
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    reset_window();
    tick();
    rst_n = 1'b1;
    tick();
    full_msg(abc, 0, abc_d);

`ifdef SHA_HOST_TIMEOUT_EN
    // Core stalls after 8 digest bytes.
    d = rand_bytes(32);
    run_msg(rand_bytes(5), 0, d, 8, 1'b1);
    cnt = 0;
    while (cnt < 4 * TMO) begin
      @(negedge clk);
      if (digest_valid) break;
      tick();
      cnt++;
    end
    check("timeout_cycles", 256'(cnt), 256'(TMO));
    tick();
    ack_digest();
    check("err_held_in_idle", 256'(err_timeout), 256'(1));
    full_msg(abc, 0, abc_d);
`endif

    check("protocol_violations", 256'(proto_err), 256'(0));
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha256_gpio_host.md
Name: sha256_gpio_host

Overview:
- Host-side driver for the byte-wide GPIO SHA-256 interface.
- Takes a message as a byte stream from an upstream source (UART/FIFO/CPU shim) and drives din/valid/last into the hashing core, honouring its ready and busy signals.
- Then captures the 32 digest bytes returned on dout/dvalid, assembles them into a 256-bit word and presents it with a valid/ack handshake.

Parameters:
- LEN_W, 16, width of the sent-byte counter and of msg_len.
- TIMEOUT_CYCLES, 4096, maximum idle cycles between digest bytes while collecting (used only with SHA_HOST_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_data  input  8  upstream message byte
- s_valid  input  1  upstream byte valid
- s_last  input  1  marks final message byte
- s_ready  output  1  upstream byte accepted this cycle
- gpio_din  output  8  byte to core din
- gpio_valid  output  1  byte strobe to core
- gpio_last  output  1  last flag to core
- gpio_ready  input  1  core can take a byte this cycle
- gpio_busy  input  1  core busy indicator
- gpio_dout  input  8  digest byte from core
- gpio_dvalid  input  1  digest byte strobe from core
- digest  output  256  assembled digest; first received byte in [255:248]
- digest_valid  output  1  digest available, held until acked
- digest_ack  input  1  consumer accepts digest
- msg_len  output  LEN_W  bytes sent for current/last message, saturating at all-ones
- err_timeout  output  1  digest collection timed out (0 when feature off)

Behaviour:
- Reset (async assert, sync release): state=IDLE; digest=0; digest_valid=0; msg_len=0; err_timeout=0; internal byte counter=0.
- While in reset: s_ready=0, gpio_valid=0, gpio_last=0, gpio_din=0.
- States: IDLE, SEND, COLLECT, DONE.
- IDLE:
  - s_ready=0.
  - Move to SEND when s_valid=1 and gpio_busy=0.
  - On entry to SEND: clear msg_len and err_timeout; leave digest untouched.
- SEND:
  - gpio_valid = s_valid & gpio_ready, combinational; s_ready equals gpio_valid.
  - gpio_din = s_data and gpio_last = s_last, passed through.
  - Transfer happens only when gpio_valid=1. No byte is ever presented while gpio_ready=0, so the core skid buffer is never relied on.
  - Each transfer increments msg_len (saturating).
  - A transfer with s_last=1 moves to COLLECT next cycle, clears the byte counter and clears digest_valid.
- COLLECT:
  - s_ready=0 and gpio_valid=0.
  - Each gpio_dvalid shifts gpio_dout into digest from the LSB end (digest <= {digest[247:0], gpio_dout}). After 32 bytes the first byte sits in [255:248].
  - 5-bit counter; the dvalid at count 31 moves to DONE and sets digest_valid=1 in the same cycle the 32nd byte lands.
- DONE:
  - digest_valid held at 1; digest stable.
  - digest_ack=1 clears digest_valid and returns to IDLE next cycle.
- Boundary conditions:
  - Minimum message is one byte with s_last=1. Zero-length messages are unsupported; s_last is only meaningful with s_valid.
  - gpio_dvalid outside COLLECT is ignored; digest is unchanged.
  - digest_ack outside DONE is ignored.
  - gpio_ready dropping mid-message stalls SEND indefinitely; no timeout applies in SEND.
  - A new message is not started while digest_valid=1. The consumer must ack first.
  - Reset mid-SEND or mid-COLLECT aborts immediately to the reset values above. Partial digest bytes are discarded.
- Latency:
  - Last byte transfer to COLLECT: 1 cycle.
  - 32nd dvalid to digest_valid=1: registered on that edge.
  - Ack to IDLE: 1 cycle.

Optional Feature:
- Macro: SHA_HOST_TIMEOUT_EN.
- When defined:
  - A counter runs in COLLECT, reset by each gpio_dvalid.
  - When it reaches TIMEOUT_CYCLES with no dvalid: set err_timeout=1, set digest_valid=1 with partial digest contents, and go to DONE.
  - err_timeout stays 1 until the next message enters SEND, or until reset.
- When undefined:
  - No counter is built; err_timeout is tied to 0.
  - COLLECT waits indefinitely.

Test Plan:
- Message "abc" (0x61,0x62,0x63 last), gpio_ready always 1 -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid=1, msg_len=3.
- Same message with gpio_ready toggling 1/0 every cycle -> gpio_valid never high while gpio_ready=0; same digest; msg_len=3.
- 64-byte message of 0x00, consumer holds digest_ack=0 for 20 cycles -> digest_valid held 20 cycles, digest stable; no s_ready while digest_valid=1; returns to IDLE 1 cycle after ack.
- Stray gpio_dvalid with gpio_dout=0xAA in IDLE -> digest unchanged; state stays IDLE.
- rst_n pulsed low after 10 digest bytes received -> all outputs at reset values; the next "abc" message yields the correct digest.
- With SHA_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, core stops after 8 digest bytes -> err_timeout=1 and digest_valid=1 after 16 idle cycles; err_timeout cleared when the next message starts.
